// File: rtl/rat_pipe_pkg.sv
// rtl/rat_pipe_pkg.sv - shared RAT pipeline constants and fetch state type
package rat_pipe_pkg;
  localparam int ADDR_W = 10;
  localparam int INSTR_W = 18;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 18'h00000;
  localparam logic [ADDR_W-1:0] INTR_VEC = 10'h3FF;

  typedef enum logic {PRIME, RUN} fetch_state_t;
endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry capture buffer holding a fetched word across a stall
module fetch_skid #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         v
);

  logic         r_v;
  logic [W-1:0] r_q;

  // clr beats cap so a squash or advance never leaves a stale word behind
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_v <= 1'b0;
      r_q <= '0;
    end else if (cap) begin
      r_v <= 1'b1;
      r_q <= d;
    end
  end

  assign q = r_q;
  assign v = r_v;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, ROM drive and IF/ID producer with stall/redirect/interrupt
module fetch_unit #(
  parameter int ADDR_W = rat_pipe_pkg::ADDR_W,
  parameter int INSTR_W = rat_pipe_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] INTR_VEC = rat_pipe_pkg::INTR_VEC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = rat_pipe_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               intr,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  addr,
  output logic               valid,
  output logic               intr_ack,
  output logic [ADDR_W-1:0]  intr_ret_pc
);
  import rat_pipe_pkg::*;

  fetch_state_t        r_st;
  logic [ADDR_W-1:0]   r_pc_q;
  logic [ADDR_W-1:0]   r_f_pc_q;

  logic                w_run;
  logic                w_take_intr;
  logic                w_squash;
  logic                w_cap;
  logic                w_clr;
  logic                w_hold_v;
  logic [INSTR_W-1:0]  w_hold_instr;
  logic [ADDR_W-1:0]   w_hold_addr;
  logic                w_cur_valid;
  logic [INSTR_W-1:0]  w_cur_instr;
  logic [ADDR_W-1:0]   w_cur_addr;

  assign w_run       = (r_st == RUN);
  assign w_take_intr = !redirect && intr && !stall && w_run;
  assign w_squash    = redirect || w_take_intr;

  // Capture only the first stalled RUN cycle; later stall cycles keep the held word
  assign w_cap = !redirect && stall && !w_hold_v && w_run;
  assign w_clr = redirect || !stall;

  fetch_skid #(
    .W(ADDR_W + INSTR_W)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .cap (w_cap),
    .clr (w_clr),
    .d   ({r_f_pc_q, rom_data}),
    .q   ({w_hold_addr, w_hold_instr}),
    .v   (w_hold_v)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc_q   <= RESET_PC;
      r_f_pc_q <= RESET_PC;
      r_st     <= PRIME;
    end else if (redirect) begin
      r_pc_q <= redirect_pc;
      r_st   <= PRIME;
    end else if (w_take_intr) begin
      r_pc_q <= INTR_VEC;
      r_st   <= PRIME;
    end else if (!stall) begin
      r_f_pc_q <= r_pc_q;
      r_pc_q   <= r_pc_q + ADDR_W'(1);
      r_st     <= RUN;
    end
  end

  // The held word takes precedence so a stall release costs no bubble
  assign w_cur_valid = w_hold_v || w_run;
  assign w_cur_instr = w_hold_v ? w_hold_instr : rom_data;
  assign w_cur_addr  = w_hold_v ? w_hold_addr  : r_f_pc_q;

  assign rom_addr    = r_pc_q;
  assign valid       = w_cur_valid && !w_squash;
  assign instr       = valid ? w_cur_instr : NOP_INSTR;
  assign addr        = valid ? w_cur_addr  : r_f_pc_q;
  assign intr_ack    = w_take_intr;
  assign intr_ret_pc = w_take_intr ? w_cur_addr : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic        intr;
  logic [9:0]  rom_addr;
  logic [17:0] rom_data;
  logic [17:0] instr;
  logic [9:0]  addr;
  logic        valid;
  logic        intr_ack;
  logic [9:0]  intr_ret_pc;

  int total = 0;
  int bad = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .intr        (intr),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .addr        (addr),
    .valid       (valid),
    .intr_ack    (intr_ack),
    .intr_ret_pc (intr_ret_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rom_data = '0;
  always @(posedge clk) rom_data <= {8'h00, rom_addr};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic obs(input string tag, input logic v, input logic [9:0] a, input logic [17:0] i);
    #1;
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".addr"},  32'(addr),  32'(a));
    chk({tag, ".instr"}, 32'(instr), 32'(i));
  endtask

  task automatic ack(input string tag, input logic k, input logic [9:0] r);
    chk({tag, ".ack"}, 32'(intr_ack), 32'(k));
    chk({tag, ".ret"}, 32'(intr_ret_pc), 32'(r));
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; intr = 1'b0;
    nxt(); nxt(); nxt();

    obs("rst", 1'b0, 10'h000, 18'h00000);
    chk("rst.rom_addr", 32'(rom_addr), 32'h000);
    ack("rst", 1'b0, 10'h000);

    rst = 1'b1;
    obs("rel0", 1'b0, 10'h000, 18'h00000);
    nxt(); obs("rel1", 1'b1, 10'h000, 18'h00000);
    nxt(); obs("rel2", 1'b1, 10'h001, 18'h00001);
    nxt(); obs("rel3", 1'b1, 10'h002, 18'h00002);
    nxt(); nxt(); nxt();

    stall = 1'b1;
    obs("stl0", 1'b1, 10'h005, 18'h00005);
    nxt(); obs("stl1", 1'b1, 10'h005, 18'h00005);
    chk("stl1.rom_addr", 32'(rom_addr), 32'h006);
    nxt(); obs("stl2", 1'b1, 10'h005, 18'h00005);
    nxt(); stall = 1'b0;
    obs("stlrel", 1'b1, 10'h005, 18'h00005);
    nxt(); obs("stl6", 1'b1, 10'h006, 18'h00006);
    nxt(); obs("stl7", 1'b1, 10'h007, 18'h00007);

    redirect = 1'b1; redirect_pc = 10'h120;
    obs("rd0", 1'b0, 10'h007, 18'h00000);
    nxt(); redirect = 1'b0;
    obs("rd1", 1'b0, 10'h007, 18'h00000);
    chk("rd1.rom_addr", 32'(rom_addr), 32'h120);
    nxt(); obs("rd2", 1'b1, 10'h120, 18'h00120);
    nxt(); obs("rd3", 1'b1, 10'h121, 18'h00121);

    redirect = 1'b1; redirect_pc = 10'h03E;
    nxt(); redirect = 1'b0;
    nxt(); obs("pre3e", 1'b1, 10'h03E, 18'h0003E);
    nxt(); obs("pre3f", 1'b1, 10'h03F, 18'h0003F);
    nxt(); intr = 1'b1;
    obs("int0", 1'b0, 10'h040, 18'h00000);
    ack("int0", 1'b1, 10'h040);
    nxt(); intr = 1'b0;
    obs("int1", 1'b0, 10'h040, 18'h00000);
    ack("int1", 1'b0, 10'h000);
    nxt(); obs("intv", 1'b1, 10'h3FF, 18'h003FF);
    nxt(); obs("wrap0", 1'b1, 10'h000, 18'h00000);
    nxt(); obs("wrap1", 1'b1, 10'h001, 18'h00001);

    nxt(); stall = 1'b1; intr = 1'b1;
    obs("dfr0", 1'b1, 10'h002, 18'h00002);
    ack("dfr0", 1'b0, 10'h000);
    nxt(); obs("dfr1", 1'b1, 10'h002, 18'h00002);
    ack("dfr1", 1'b0, 10'h000);
    nxt(); stall = 1'b0;
    obs("dfr2", 1'b0, 10'h002, 18'h00000);
    ack("dfr2", 1'b1, 10'h002);
    nxt(); intr = 1'b0;
    obs("dfr3", 1'b0, 10'h002, 18'h00000);
    ack("dfr3", 1'b0, 10'h000);
    nxt(); obs("dfr4", 1'b1, 10'h3FF, 18'h003FF);
    nxt(); obs("dfr5", 1'b1, 10'h000, 18'h00000);

    stall = 1'b1;
    nxt(); redirect = 1'b1; redirect_pc = 10'h200;
    obs("rds0", 1'b0, 10'h000, 18'h00000);
    nxt(); redirect = 1'b0; stall = 1'b0;
    obs("rds1", 1'b0, 10'h000, 18'h00000);
    nxt(); obs("rds2", 1'b1, 10'h200, 18'h00200);
    nxt(); obs("rds3", 1'b1, 10'h201, 18'h00201);

    redirect = 1'b1; redirect_pc = 10'h300;
    nxt(); redirect = 1'b0; stall = 1'b1;
    obs("pst0", 1'b0, 10'h201, 18'h00000);
    nxt(); obs("pst1", 1'b0, 10'h201, 18'h00000);
    nxt(); stall = 1'b0;
    obs("pst2", 1'b0, 10'h201, 18'h00000);
    nxt(); obs("pst3", 1'b1, 10'h300, 18'h00300);

    stall = 1'b1;
    nxt(); rst = 1'b0;
    obs("rms0", 1'b1, 10'h300, 18'h00300);
    nxt(); obs("rms1", 1'b0, 10'h000, 18'h00000);
    chk("rms1.rom_addr", 32'(rom_addr), 32'h000);
    ack("rms1", 1'b0, 10'h000);
    rst = 1'b1; stall = 1'b0;
    nxt(); obs("rms2", 1'b1, 10'h000, 18'h00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front end of the pipelined RAT core. Generates the program counter, drives the synchronous program ROM and presents instruction/address pairs to the IF/ID pipeline register. It is the producer side of that register: the fetch unit and the register share the same `stall` and the same data widths. It also absorbs stall, branch redirect and interrupt vectoring without losing or duplicating an instruction.

## Interface
Parameters:
- `ADDR_W`, 10, program address width
- `INSTR_W`, 18, instruction width
- `RESET_PC`, 10'h000, first fetch address after reset
- `INTR_VEC`, 10'h3FF, interrupt vector address
- `NOP_INSTR`, 18'h00000, bubble instruction, equal to the IF/ID register reset contents

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  synchronous reset, active-low (0 = reset)
- `stall`  in  1  hazard stall; the IF/ID register does not capture while it is high
- `redirect`  in  1  taken branch/call/return from a later stage
- `redirect_pc`  in  ADDR_W  target address for `redirect`
- `intr`  in  1  level interrupt request, already masked by the interrupt-enable logic
- `rom_addr`  out  ADDR_W  ROM read address; data returns on `rom_data` the following cycle
- `rom_data`  in  INSTR_W  ROM read data
- `instr`  out  INSTR_W  instruction to the IF/ID register
- `addr`  out  ADDR_W  address of `instr`
- `valid`  out  1  `instr` is a correct-path instruction (0 means `instr` = NOP_INSTR)
- `intr_ack`  out  1  one-cycle pulse when an interrupt is taken
- `intr_ret_pc`  out  ADDR_W  return address; meaningful only while `intr_ack` is high

## Operation
State registers:
- `pc_q`: next request address; `rom_addr = pc_q`.
- `f_pc_q`: address whose data is on `rom_data`.
- `hold_v`, `hold_instr`, `hold_addr`: hold buffer.
- `st`: one of PRIME, RUN.

Output selection:
- When `hold_v` = 1: output the hold buffer.
- Otherwise, when `st` = RUN: output `rom_data` / `f_pc_q`.
- In PRIME, or in any squash cycle: `instr` = NOP_INSTR, `valid` = 0, `addr` = `f_pc_q`.

Per-cycle priority (highest first):
- **Reset**: `pc_q` = RESET_PC; `f_pc_q` = RESET_PC; `hold_v` = 0; `st` = PRIME.
- **Redirect** (`redirect` = 1, stall ignored):
  - squash the current output;
  - `pc_q` ← `redirect_pc`; `hold_v` ← 0; `st` ← PRIME.
- **Interrupt** (`intr` = 1 and `stall` = 0 and `st` = RUN):
  - squash the current output;
  - `intr_ack` = 1; `intr_ret_pc` = the squashed `addr`;
  - `pc_q` ← INTR_VEC; `hold_v` ← 0; `st` ← PRIME.
- **Stall** (`stall` = 1):
  - `pc_q` and `f_pc_q` hold.
  - If `hold_v` = 0 and `st` = RUN: capture `rom_data` / `f_pc_q` into the hold buffer and set `hold_v` ← 1. The ROM then re-reads `pc_q`, so `rom_data` settles to `pc_q`'s word.
  - If `hold_v` = 1: the hold buffer is unchanged.
- **Advance**:
  - `f_pc_q` ← `pc_q`; `pc_q` ← `pc_q` + 1 (mod 2^ADDR_W, so 3FF wraps to 000).
  - `hold_v` ← 0; `st` ← RUN.

State transitions:
- PRIME → RUN on the first non-stalled cycle.
- PRIME with `stall` = 1 stays in PRIME and captures nothing.
- A redirect or interrupt in RUN → PRIME.

Interrupt and stall interactions:
- An interrupt is never taken while stalled or in PRIME. It is deferred, not dropped, because `intr` is level.
- A redirect concurrent with an interrupt: the redirect wins, and the interrupt is retaken later in RUN.

## Timing
- Reset values of all outputs:
  - `rom_addr` = RESET_PC
  - `instr` = NOP_INSTR
  - `addr` = RESET_PC
  - `valid` = 0
  - `intr_ack` = 0
  - `intr_ret_pc` = 0
- First valid instruction (`addr` = RESET_PC) appears 1 cycle after `rst` deasserts, provided there is no stall.
- Redirect or interrupt penalty: exactly 2 bubble cycles (the request cycle plus the PRIME cycle). The target instruction is output on the 3rd cycle.
- Stall release has zero bubbles:
  - the held word is output on the release cycle;
  - the next sequential word follows the cycle after.
- `instr`, `addr` and `valid` are stable for every cycle that `stall` is high.
- `rst` low mid-stall or mid-squash: reset values apply on the next edge.
- `intr_ack` is never high on two consecutive cycles.

## Structure
- Shared package `rat_pipe_pkg` holds:
  - `ADDR_W`, `INSTR_W`, `NOP_INSTR`, `INTR_VEC`;
  - `typedef enum logic {PRIME, RUN} fetch_state_t`.
  - The IF/ID register and the decoder use the same constants.
- The hold buffer is a natural sub-module, `fetch_skid`: a 1-entry capture/bypass with `cap`, `clr`, `d`, `q`, `v`. The PC and state logic stay in `fetch_unit`.

## Test plan
ROM model: registered read, `rom_data` = {8'h00, addr}.
- **Reset release**: `rst` 0→1 → cycle 0: `valid` = 0; then `addr` 000, 001, 002 with `instr` 0x00000, 0x00001, 0x00002, `valid` = 1.
- **Stall hold**: `stall` high for 3 cycles while `addr` = 005 → outputs stay 005 / 0x00005 throughout; release cycle shows 005, then 006, 007 with no gap.
- **Redirect**: `redirect` = 1, `redirect_pc` = 0x120 while `addr` = 007 → `valid` 0 for 2 cycles, then `addr` 0x120, 0x121; 008 never appears.
- **Interrupt and wrap**: `intr` = 1 at `addr` = 0x040 → `intr_ack` pulse with `intr_ret_pc` = 0x040; 2 bubbles; then `addr` 3FF, 000, 001.
- **Interrupt deferral**: `intr` held high during a stall → no `intr_ack` until the first non-stalled RUN cycle.
- **Redirect during stall**: redirect asserted during a stall → the redirect is taken immediately and the hold buffer is discarded.
- **Reset mid-stall**: `rst` pulled low during a stall → next cycle shows all reset values.
